// File: rtl/token_bucket_scheduler.sv
// Round-robin arbiter that fires a fixed-width shared pulse per grant, rate-limited by a token bucket.
// Latency: grant and pulse_out rise on the edge after req is seen in IDLE; grants are spaced by PULSE_LEN+2 or more.
// Backpressure: req is a level and is only sampled in IDLE with tokens > 0; it is never latched.
module token_bucket_scheduler #(
  parameter int NREQ          = 4,
  parameter int PULSE_LEN     = 6,
  parameter int BUCKET_DEPTH  = 4,
  parameter int REFILL_PERIOD = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NREQ-1:0]                       req,
  output logic [NREQ-1:0]                       grant,
  output logic                                  pulse_out,
  output logic [$clog2(NREQ)-1:0]               active_id,
  output logic [$clog2(BUCKET_DEPTH+1)-1:0]     tokens,
  output logic                                  busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(BUCKET_DEPTH + 1);
  localparam int PCW = $clog2(PULSE_LEN + 1);
  localparam int RCW = $clog2(REFILL_PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [PCW-1:0]   pcnt_q, pcnt_d;
  logic [RCW-1:0]   rcnt_q;
  logic             refill_tick;
  logic             take;
  logic             win_vld;
  logic [IDW-1:0]   win_id;
  int               idx;

  // Walk offsets from farthest to nearest so the requester closest after active_id wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = active_id;
    idx     = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(active_id) + i) % NREQ;
      if (req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  assign take        = (state_q == IDLE) && win_vld && (tokens != '0);
  assign refill_tick = (rcnt_q == RCW'(REFILL_PERIOD - 1));

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = FIRE;
          pcnt_d  = PCW'(PULSE_LEN);
        end
      end
      FIRE: begin
        pcnt_d = pcnt_q - PCW'(1);
        if (pcnt_q == PCW'(1)) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      grant     <= '0;
      active_id <= IDW'(NREQ - 1);
      tokens    <= TW'(BUCKET_DEPTH);
      rcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      rcnt_q  <= refill_tick ? '0 : rcnt_q + RCW'(1);
      grant   <= take ? ({{(NREQ-1){1'b0}}, 1'b1} << win_id) : '0;
      if (take) active_id <= win_id;
      // A tick coinciding with a consume cancels out; a tick into a full bucket is dropped.
      if (refill_tick && !take && tokens < TW'(BUCKET_DEPTH))
        tokens <= tokens + TW'(1);
      else if (take && !refill_tick)
        tokens <= tokens - TW'(1);
    end
  end

  assign pulse_out = (state_q == FIRE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_token_bucket_scheduler.sv
// Directed bench: per-cycle vector table for the single-request case plus hand sequences for multi-cycle corners.
module tb_token_bucket_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic [3:0] grant, grant64;
  logic       pulse_out, pulse64;
  logic [1:0] active_id, active64;
  logic [2:0] tokens, tok64;
  logic       busy, busy64;

  int checks;
  int errors;

  always #5 clk = ~clk;

  token_bucket_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .pulse_out(pulse_out),
    .active_id(active_id), .tokens(tokens), .busy(busy)
  );

  token_bucket_scheduler #(.REFILL_PERIOD(64)) dut64 (
    .clk(clk), .rst(rst), .req(req), .grant(grant64), .pulse_out(pulse64),
    .active_id(active64), .tokens(tok64), .busy(busy64)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       pulse;
    logic       busy;
    logic [2:0] tokens;
    logic [1:0] active;
  } vec_t;

  vec_t       vecs[11];
  int         gcyc[8];
  logic [3:0] gval[8];
  logic [3:0] rr_exp[5];
  logic [3:0] ex_exp[5];
  int         ex_cyc[5];
  int         n, run, maxrun, bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 4'b0000;

    //            rst  req      grant    pls  bsy  tok   act
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd4, 2'd3};
    vecs[1]  = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 3'd4, 2'd3};
    vecs[2]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 3'd3, 2'd0};
    vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 3'd3, 2'd0};
    vecs[4]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 3'd3, 2'd0};
    vecs[5]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 3'd3, 2'd0};
    vecs[6]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 3'd3, 2'd0};
    vecs[7]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 3'd3, 2'd0};
    vecs[8]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd3, 2'd0};
    vecs[9]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 3'd4, 2'd0};
    vecs[10] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 3'd3, 2'd0};

    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ex_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
    ex_cyc = '{0, 8, 16, 24, 64};

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      step();
      chk($sformatf("vec%0d_grant", i), grant, vecs[i].grant);
      chk($sformatf("vec%0d_pulse", i), pulse_out, vecs[i].pulse);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_tokens", i), tokens, vecs[i].tokens);
      chk($sformatf("vec%0d_active", i), active_id, vecs[i].active);
    end

    // Round-robin with all requesters held.
    do_reset();
    rst = 1'b0;
    req = 4'b1111;
    n = 0; run = 0; maxrun = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      if (grant != 4'b0000 && n < 8) begin
        gcyc[n] = cyc;
        gval[n] = grant;
        n++;
      end
      if (pulse_out) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    chk("rr_grant_count", n, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d_val", k), gval[k], rr_exp[k]);
      chk($sformatf("rr_grant%0d_cyc", k), gcyc[k], 8 * k);
    end
    chk("rr_max_pulse_run", maxrun, 6);

    // Reset in the third FIRE cycle.
    do_reset();
    rst = 1'b0;
    req = 4'b0001;
    step();
    chk("rstmid_grant0", grant, 4'b0001);
    step();
    step();
    chk("rstmid_pulse_3rd", pulse_out, 1'b1);
    rst = 1'b1;
    step();
    chk("rstmid_pulse", pulse_out, 1'b0);
    chk("rstmid_grant", grant, 4'b0000);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_tokens", tokens, 3'd4);
    chk("rstmid_active", active_id, 2'd3);
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("rstmid_first_grant", grant, 4'b0001);
    chk("rstmid_tokens_after", tokens, 3'd3);

    // Full bucket with no requests stays full.
    do_reset();
    rst = 1'b0;
    bad = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      step();
      if (tokens != 3'd4) bad++;
    end
    chk("full_bucket_cycles_off", bad, 0);

    // Bucket exhaustion with a slow refill.
    do_reset();
    rst = 1'b0;
    req = 4'b0011;
    n = 0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      step();
      if (grant64 != 4'b0000 && n < 8) begin
        gcyc[n] = cyc;
        gval[n] = grant64;
        n++;
      end
      if (cyc == 40 || cyc == 62) chk($sformatf("ex_tokens_c%0d", cyc), tok64, 3'd0);
      if (cyc == 63) begin
        chk("ex_tokens_refilled", tok64, 3'd1);
        chk("ex_no_grant_at_tick", grant64, 4'b0000);
      end
      if (cyc == 64) chk("ex_tokens_after_regrant", tok64, 3'd0);
    end
    chk("ex_grant_count", n, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ex_grant%0d_val", k), gval[k], ex_exp[k]);
      chk($sformatf("ex_grant%0d_cyc", k), gcyc[k], ex_cyc[k]);
    end

    // Grant landing on the refill tick at tokens == 2.
    do_reset();
    rst = 1'b0;
    req = 4'b0001;
    step();
    for (int cyc = 1; cyc <= 8; cyc++) step();
    chk("tickgrant_second_grant", grant64, 4'b0001);
    chk("tickgrant_tokens_pre", tok64, 3'd2);
    req = 4'b0000;
    for (int cyc = 9; cyc <= 62; cyc++) step();
    chk("tickgrant_idle_before", busy64, 1'b0);
    req = 4'b0001;
    step();
    chk("tickgrant_grant", grant64, 4'b0001);
    chk("tickgrant_tokens", tok64, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/token_bucket_scheduler.md
TOKEN_BUCKET_SCHEDULER -- requirements
Module: token_bucket_scheduler

Interface
REQ-001 The module SHALL have a parameter NREQ, default 4, giving the number of requesters; legal values are 2..8.
REQ-002 The module SHALL have a parameter PULSE_LEN, default 6, giving the output pulse width in cycles; legal values are 1 and above.
REQ-003 The module SHALL have a parameter BUCKET_DEPTH, default 4, giving the token capacity; legal values are 1 and above.
REQ-004 The module SHALL have a parameter REFILL_PERIOD, default 8, giving the number of cycles per token refill; legal values are 2 and above.
REQ-005 The module SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port req, input, NREQ bits: level request per requester, held until granted.
REQ-009 Port grant, output, NREQ bits: one-hot, one-cycle grant strobe.
REQ-010 Port pulse_out, output, 1 bit: the shared one-shot pulse.
REQ-011 Port active_id, output, $clog2(NREQ) bits: index of the last granted requester.
REQ-012 Port tokens, output, $clog2(BUCKET_DEPTH+1) bits: current bucket level.
REQ-013 Port busy, output, 1 bit: high while the state machine is in FIRE or GAP.

Function
REQ-014 The state machine SHALL have three states: IDLE, FIRE and GAP.
REQ-015 In IDLE, when req is nonzero and tokens > 0, the next edge SHALL set grant to the one-hot winner, load the pulse counter with PULSE_LEN, decrement tokens, update active_id, and move to FIRE.
REQ-016 grant SHALL be high only in the first FIRE cycle, and SHALL be zero in every other cycle.
REQ-017 pulse_out SHALL equal (state == FIRE), giving exactly PULSE_LEN high cycles per grant, starting in the same cycle as grant.
REQ-018 FIRE SHALL decrement the pulse counter each cycle and go to GAP after its PULSE_LEN-th cycle.
REQ-019 GAP SHALL last exactly one cycle and then return to IDLE, so the minimum grant-to-grant spacing is PULSE_LEN+2 cycles.
REQ-020 Requests arriving during FIRE or GAP SHALL be neither lost nor latched; req is re-sampled in IDLE.
REQ-021 Arbitration SHALL be round-robin: the search starts at (active_id+1) mod NREQ, and the first asserted req wins.
REQ-022 After reset, active_id SHALL be NREQ-1, so requester 0 has the highest priority.
REQ-023 A requester whose req is still high after its own pulse SHALL be treated as a new request, subject to round-robin.
REQ-024 A req deasserted before it is granted SHALL have no effect.
REQ-025 A free-running refill counter SHALL count 0..REFILL_PERIOD-1 and wrap; the wrap cycle is the refill tick.
REQ-026 The refill counter SHALL run regardless of state or bucket level.
REQ-027 On a refill tick, tokens SHALL increment, saturating at BUCKET_DEPTH.
REQ-028 When a tick and a consume occur on the same edge, tokens SHALL be unchanged.
REQ-029 When tokens == BUCKET_DEPTH, a tick SHALL be discarded.
REQ-030 The grant decision SHALL use the registered tokens value: after a tick raises tokens from 0 to 1, the earliest grant is the following edge.
REQ-031 With tokens == 0 and req pending, the module SHALL stay in IDLE with grant = 0 and pulse_out = 0.

Reset
REQ-032 rst SHALL be sampled only on the rising edge of clk.
REQ-033 While rst is high: state = IDLE, grant = 0, pulse_out = 0, busy = 0, tokens = BUCKET_DEPTH, active_id = NREQ-1, refill counter = 0.
REQ-034 rst asserted mid-pulse SHALL force pulse_out low on the next edge; the aborted pulse SHALL NOT be resumed or refunded.
REQ-035 The first grant SHALL be possible on the first edge at which rst is sampled low.

Verification (defaults unless stated)
REQ-036 Single request: req = 0001 held after reset -> grant = 0001 for 1 cycle; pulse_out high exactly 6 cycles; tokens 4 -> 3; busy high 7 cycles.
REQ-037 Round-robin: req = 1111 held continuously -> grant order 0, 1, 2, 3, 0; grants exactly 8 cycles apart; pulse_out never high for more than 6 consecutive cycles.
REQ-038 Bucket exhaustion: REFILL_PERIOD = 64, req = 0011 held -> 4 grants at 8-cycle spacing, then tokens = 0 and no grant; the next grant comes exactly 1 cycle after tokens returns to 1.
REQ-039 Simultaneous tick and grant: align a grant with a refill tick at tokens = 2 -> tokens remains 2; with tokens = 4 and no requests for 100 cycles -> tokens stays 4.
REQ-040 Reset mid-pulse: assert rst in the 3rd FIRE cycle -> pulse_out, grant and busy are 0 on the next edge; tokens = 4; with req = 1111 after release, the first grant goes to requester 0.
